daq_sram_writer: RTL and testbench
==================================

DAQ_SRAM_WRITER -- requirements
Module: daq_sram_writer

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: SRAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 32: SRAM word width; matches the channel data_out width.
REQ-003 wb_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 wb_rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  writer enable from firmware control.
REQ-006 start_sram  input  1  channel has a packed word on data_in; held high until data_done.
REQ-007 data_in  input  DATA_WIDTH  packed sample word from the DAQ channel.
REQ-008 data_done  output  1  one-cycle pulse: word committed to SRAM.
REQ-009 base_addr  input  ADDR_WIDTH  ring-buffer base word address.
REQ-010 buffer_words  input  ADDR_WIDTH  ring length in words; 0 means 2^ADDR_WIDTH.
REQ-011 ptr_clear  input  1  pulse; resets the write offset to 0.
REQ-012 sram_req  output  1  SRAM write request; the write strobe.
REQ-013 sram_gnt  input  1  arbiter grant; the write completes on the cycle sram_req and sram_gnt are both high.
REQ-014 sram_addr  output  ADDR_WIDTH  write address.
REQ-015 sram_data  output  DATA_WIDTH  write data.
REQ-016 wr_offset  output  ADDR_WIDTH  current ring offset, 0..buffer_words-1.
REQ-017 wrap_irq  output  1  one-cycle pulse when the last ring slot is written.
REQ-018 words_written  output  32  saturating count of committed words; present only with the configuration macro.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, WRITE, DONE, HOLD.
REQ-020 In IDLE with enable=1 and start_sram=1, the block SHALL do the following on the same edge:
- latch data_in into sram_data;
- latch base_addr+wr_offset (mod 2^ADDR_WIDTH) into sram_addr;
- set sram_req=1;
- enter WRITE.
REQ-021 In WRITE, sram_req, sram_addr and sram_data SHALL be held stable until sram_gnt=1; on that edge sram_req SHALL drop and the FSM SHALL enter DONE.
REQ-022 In DONE, data_done SHALL be 1 for exactly one cycle, the offset SHALL advance, and the next state SHALL be HOLD.
REQ-023 HOLD SHALL last one cycle, ignore start_sram and return to IDLE; this gives the channel one cycle to drop start_sram or present the next word.
REQ-024 Minimum start_sram-to-data_done latency SHALL be 2 cycles (grant on the first WRITE cycle); maximum word rate SHALL be one word per 4 cycles.
REQ-025 Offset advance SHALL be offset+1, or 0 when offset = buffer_words-1. In the wrap case wrap_irq SHALL pulse in the same cycle as data_done.
REQ-026 buffer_words=0 SHALL wrap at 2^ADDR_WIDTH-1. base_addr+offset overflow SHALL wrap modulo 2^ADDR_WIDTH.
REQ-027 base_addr and buffer_words SHALL be sampled only in IDLE; changes during WRITE/DONE/HOLD take effect on the next word.
REQ-028 A ptr_clear in IDLE SHALL zero the offset on the next edge.
REQ-029 A ptr_clear in any other state SHALL be latched and applied on the cycle HOLD exits. If it coincides with a DONE advance, the clear wins.
REQ-030 enable=0 during WRITE SHALL NOT abort the transaction; the sequence completes through HOLD, and IDLE then ignores start_sram.
REQ-031 If start_sram is low in IDLE, the FSM SHALL remain in IDLE with sram_req=0.

Reset
REQ-032 On wb_rst the block SHALL enter IDLE and clear the following to 0: sram_req, data_done, wrap_irq, sram_addr, sram_data, wr_offset, the pending ptr_clear flag, and words_written.
REQ-033 A reset mid-WRITE SHALL drop sram_req on the next edge; the word is lost and data_done is not issued.

Configuration
REQ-034 Macro DAQ_SRAM_WRITER_STATS_EN SHALL control the words_written statistics counter.
- Defined: words_written SHALL increment on each data_done and saturate at 32'hFFFFFFFF.
- Undefined: words_written SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-035 Shared package daq_pkg SHALL hold the FSM state encodings (IDLE=0, WRITE=1, DONE=2, HOLD=3) and the default ADDR_WIDTH/DATA_WIDTH constants.
REQ-036 Sub-module daq_ring_ptr SHALL contain the offset register, wrap compare, pending-clear flag and wrap_irq generation; the FSM and SRAM register stay in the top level.

Verification
REQ-037 Contiguous words: base=0x100, len=4, grant always high, channel words 32'h03020100, 32'h07060504 -> SRAM writes to 0x100 and 0x101 with those data, data_done 2 cycles after each start_sram.
REQ-038 Wrap: base=0x3FE, len=4, 5 words -> addresses 0x3FE, 0x3FF, 0x000, 0x001, 0x3FE; wrap_irq pulses once, with the 4th data_done.
REQ-039 Grant stall: sram_gnt held low 7 cycles -> sram_req, sram_addr and sram_data stable for all 8 cycles; data_done on cycle 9; exactly one write.
REQ-040 ptr_clear during WRITE at offset 2 -> current word written at base+2, next word written at base+0.
REQ-041 enable dropped mid-WRITE with start_sram still high -> current word completes with one data_done; no further sram_req while enable=0.
REQ-042 Reset asserted during WRITE -> sram_req=0 the next cycle, wr_offset=0, no data_done; with STATS_EN, words_written=0.

Source files
------------

// File: rtl/daq_pkg.sv
// daq_pkg: shared definitions for the DAQ SRAM writer slice.
//   daq_state_t    - writer FSM state encoding (IDLE=0, WRITE=1, DONE=2, HOLD=3)
//   DAQ_ADDR_WIDTH - default SRAM word-address width
//   DAQ_DATA_WIDTH - default SRAM word width
package daq_pkg;

  localparam int DAQ_ADDR_WIDTH = 10;
  localparam int DAQ_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    HOLD  = 2'd3
  } daq_state_t;

endpackage

// File: rtl/daq_ring_ptr.sv
// daq_ring_ptr: ring-buffer write offset for the DAQ SRAM writer.
// Ports:
//   wb_clk, wb_rst - clock, synchronous active-high reset
//   idle           - writer FSM is in IDLE
//   sample         - a word is being accepted; latch the ring length
//   advance        - word committed (DONE); step the offset
//   hold_exit      - FSM leaves HOLD this cycle; apply any pending clear
//   ptr_clear      - request to reset the offset to 0
//   buffer_words   - ring length in words (0 = full 2^ADDR_WIDTH)
//   wr_offset      - current offset
//   wrap_irq       - pulses with advance when the last slot was written
module daq_ring_ptr #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  idle,
  input  logic                  sample,
  input  logic                  advance,
  input  logic                  hold_exit,
  input  logic                  ptr_clear,
  input  logic [ADDR_WIDTH-1:0] buffer_words,
  output logic [ADDR_WIDTH-1:0] wr_offset,
  output logic                  wrap_irq
);

  logic [ADDR_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic                  clr_pend;
  logic                  at_last;

  // buffer_words-1 underflows to all-ones for a length of 0, which is
  // exactly the 2^ADDR_WIDTH ring.
  assign at_last   = (offset == last_idx);
  assign wrap_irq  = advance && at_last;
  assign wr_offset = offset;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      offset   <= '0;
      last_idx <= '1;
      clr_pend <= 1'b0;
    end else begin
      if (sample) begin
        last_idx <= buffer_words - ADDR_WIDTH'(1);
      end
      if (idle) begin
        if (ptr_clear) begin
          offset <= '0;
        end
      end else if (hold_exit) begin
        if (clr_pend || ptr_clear) begin
          offset <= '0;
        end
        clr_pend <= 1'b0;
      end else begin
        if (ptr_clear) begin
          clr_pend <= 1'b1;
        end
        // A clear seen during DONE is still pending here and overrides
        // this advance when HOLD exits.
        if (advance) begin
          offset <= at_last ? '0 : offset + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/daq_sram_writer.sv
// daq_sram_writer: commits packed DAQ channel words into an SRAM ring buffer
// through a request/grant arbiter port.
// Ports:
//   wb_clk, wb_rst        - clock, synchronous active-high reset
//   enable                - writer enable
//   start_sram, data_in   - channel word handshake (held until data_done)
//   data_done             - one-cycle pulse when the word is committed
//   base_addr             - ring base word address
//   buffer_words          - ring length (0 = 2^ADDR_WIDTH)
//   ptr_clear             - reset the ring offset to 0
//   sram_req, sram_gnt    - write strobe / arbiter grant
//   sram_addr, sram_data  - write address / data
//   wr_offset             - current ring offset
//   wrap_irq              - pulse when the last ring slot is written
//   words_written         - saturating committed-word count
// Configuration: define DAQ_SRAM_WRITER_STATS_EN to build the words_written
// counter; otherwise words_written is tied to 0.
module daq_sram_writer
  import daq_pkg::*;
#(
  parameter int ADDR_WIDTH = DAQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = DAQ_DATA_WIDTH
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  enable,
  input  logic                  start_sram,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  data_done,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] buffer_words,
  input  logic                  ptr_clear,
  output logic                  sram_req,
  input  logic                  sram_gnt,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_data,
  output logic [ADDR_WIDTH-1:0] wr_offset,
  output logic                  wrap_irq,
  output logic [31:0]           words_written
);

  daq_state_t state, state_nxt;
  logic       accept;

  assign accept = (state == IDLE) && enable && start_sram;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WRITE;
      WRITE:   if (sram_gnt) state_nxt = DONE;
      DONE:    state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      sram_req  <= 1'b0;
      sram_addr <= '0;
      sram_data <= '0;
    end else if (accept) begin
      sram_req  <= 1'b1;
      sram_addr <= base_addr + wr_offset;
      sram_data <= data_in;
    end else if ((state == WRITE) && sram_gnt) begin
      sram_req  <= 1'b0;
    end
  end

  assign data_done = (state == DONE);

  daq_ring_ptr #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ring_ptr (
    .wb_clk       (wb_clk),
    .wb_rst       (wb_rst),
    .idle         (state == IDLE),
    .sample       (accept),
    .advance      (state == DONE),
    .hold_exit    (state == HOLD),
    .ptr_clear    (ptr_clear),
    .buffer_words (buffer_words),
    .wr_offset    (wr_offset),
    .wrap_irq     (wrap_irq)
  );

`ifdef DAQ_SRAM_WRITER_STATS_EN
  logic [31:0] words_cnt;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      words_cnt <= '0;
    end else if (data_done && (words_cnt != '1)) begin
      words_cnt <= words_cnt + 32'd1;
    end
  end

  assign words_written = words_cnt;
`else
  assign words_written = '0;
`endif

endmodule

// File: tb/tb_daq_sram_writer.sv
module tb_daq_sram_writer;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int RING = 1 << AW;

  logic          wb_clk;
  logic          wb_rst;
  logic          enable;
  logic          start_sram;
  logic [DW-1:0] data_in;
  logic          data_done;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] buffer_words;
  logic          ptr_clear;
  logic          sram_req;
  logic          sram_gnt;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic [AW-1:0] wr_offset;
  logic          wrap_irq;
  logic [31:0]   words_written;

  daq_sram_writer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .wb_clk        (wb_clk),
    .wb_rst        (wb_rst),
    .enable        (enable),
    .start_sram    (start_sram),
    .data_in       (data_in),
    .data_done     (data_done),
    .base_addr     (base_addr),
    .buffer_words  (buffer_words),
    .ptr_clear     (ptr_clear),
    .sram_req      (sram_req),
    .sram_gnt      (sram_gnt),
    .sram_addr     (sram_addr),
    .sram_data     (sram_data),
    .wr_offset     (wr_offset),
    .wrap_irq      (wrap_irq),
    .words_written (words_written)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge wb_clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [AW-1:0] off;
    logic          wrap;
    int            req_cycles;  // -1: grant timing not predicted
  } exp_t;

  exp_t expq[$];
  int   m_off  = 0;
  int   m_base = 0;
  int   m_len  = 0;

  int gnt_mode  = 0;  // 0 always granted, 1 random, 2 fixed stall
  int stall_len = 0;
  int req_cnt   = 0;

  function automatic exp_t model_issue(input logic [DW-1:0] d);
    exp_t e;
    int   len_eff;
    len_eff      = (m_len == 0) ? RING : m_len;
    e.addr       = AW'((m_base + m_off) % RING);
    e.data       = d;
    e.off        = AW'(m_off);
    e.wrap       = (m_off == len_eff - 1);
    m_off        = e.wrap ? 0 : (m_off + 1) % RING;
    e.req_cycles = (gnt_mode == 2) ? stall_len + 1 : -1;
    return e;
  endfunction

  // ---------------- arbiter grant ----------------
  initial sram_gnt = 1'b0;
  always @(posedge wb_clk) begin
    #1;
    if (gnt_mode == 0) begin
      sram_gnt = 1'b1;
    end else if (gnt_mode == 1) begin
      sram_gnt = 1'($urandom_range(0, 1));
    end else begin
      req_cnt  = sram_req ? req_cnt + 1 : 0;
      sram_gnt = (req_cnt >= stall_len + 1);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic          in_req   = 1'b0;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic          stable;
  int            rc;
  logic          cur_wrap = 1'b0;
  logic          pend_done = 1'b0;
  int            done_since_rst = 0;
  exp_t          me;

  always @(negedge wb_clk) begin
    if (wb_rst) begin
      in_req         = 1'b0;
      pend_done      = 1'b0;
      done_since_rst = 0;
    end else begin
      if (pend_done) begin
        check("done_after_grant", data_done, 1'b1);
        check("wrap_irq", wrap_irq, cur_wrap);
        pend_done = 1'b0;
      end else if (data_done || wrap_irq) begin
        checks++;
        failures++;
        $display("FAIL spurious_pulse: got done=%0b wrap=%0b expected 0 0 (cycle %0d)",
                 data_done, wrap_irq, cyc);
      end
      if (data_done) done_since_rst++;

      if (sram_req) begin
        if (!in_req) begin
          cap_addr = sram_addr;
          cap_data = sram_data;
          stable   = 1'b1;
          rc       = 0;
          in_req   = 1'b1;
        end else if (sram_addr !== cap_addr || sram_data !== cap_data) begin
          stable = 1'b0;
        end
        rc++;
        if (sram_gnt) begin
          in_req = 1'b0;
          if (expq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", sram_addr, sram_data);
          end else begin
            me = expq.pop_front();
            check("sram_addr", sram_addr, me.addr);
            check("sram_data", sram_data, me.data);
            check("wr_offset", wr_offset, me.off);
            check("req_stable", stable, 1'b1);
            if (me.req_cycles >= 0) check("req_cycles", rc, me.req_cycles);
            cur_wrap  = me.wrap;
            pend_done = 1'b1;
          end
        end
      end else begin
        in_req = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    do begin
      @(negedge wb_clk);
      n++;
    end while (!data_done && n < 300);
    if (!data_done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no data_done expected one within 300 cycles", nm);
    end
  endtask

  task automatic clear_idle();
    ptr_clear = 1'b1;
    tick();
    ptr_clear = 1'b0;
    m_off = 0;
  endtask

  // clr_mode: 0 none, 1 ptr_clear during WRITE, 2 ptr_clear during DONE
  task automatic send_word(input logic [DW-1:0] d, input int clr_mode, output int lat);
    exp_t e;
    int   c0;
    e = model_issue(d);
    if (clr_mode != 0) m_off = 0;
    expq.push_back(e);
    data_in    = d;
    start_sram = 1'b1;
    c0         = cyc;
    if (clr_mode == 1) begin
      tick();
      ptr_clear = 1'b1;
      tick();
      ptr_clear = 1'b0;
    end
    wait_done("send");
    lat = cyc - c0;
    if (clr_mode == 2) ptr_clear = 1'b1;
    tick();
    ptr_clear  = 1'b0;
    start_sram = 1'b0;
    tick();
  endtask

  // start_sram held high across words; next word presented during HOLD
  task automatic burst(input int n);
    exp_t          e;
    logic [DW-1:0] d;
    int            c_prev = 0;
    start_sram = 1'b1;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      e = model_issue(d);
      expq.push_back(e);
      data_in = d;
      wait_done("burst");
      if (i > 0) check("burst_spacing", cyc - c_prev, 4);
      c_prev = cyc;
      tick();
    end
    start_sram = 1'b0;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int reqs;
    wb_rst       = 1'b1;
    enable       = 1'b0;
    start_sram   = 1'b0;
    data_in      = '0;
    base_addr    = '0;
    buffer_words = '0;
    ptr_clear    = 1'b0;
    repeat (3) tick();
    check("rst_sram_req", sram_req, 1'b0);
    check("rst_data_done", data_done, 1'b0);
    check("rst_wrap_irq", wrap_irq, 1'b0);
    check("rst_sram_addr", sram_addr, '0);
    check("rst_sram_data", sram_data, '0);
    check("rst_wr_offset", wr_offset, '0);
    check("rst_words_written", words_written, '0);
    wb_rst = 1'b0;
    tick();

    // idle with start low: no request
    enable = 1'b1;
    repeat (3) tick();
    check("idle_no_req", sram_req, 1'b0);

    // contiguous words, minimum latency, then max-rate burst
    gnt_mode = 0;
    base_addr = 10'h100; m_base = 'h100;
    buffer_words = 10'd4; m_len = 4;
    send_word(32'h03020100, 0, lat);
    check("latency_w0", lat, 2);
    send_word(32'h07060504, 0, lat);
    check("latency_w1", lat, 2);
    burst(3);

    // wrap across the top of the address space
    clear_idle();
    base_addr = 10'h3FE; m_base = 'h3FE;
    for (int i = 0; i < 5; i++) send_word($urandom, 0, lat);

    // grant stall of 7 cycles
    gnt_mode = 2; stall_len = 7;
    send_word($urandom, 0, lat);
    check("stall_latency", lat, 9);

    // ptr_clear during WRITE at offset 2, then during DONE
    gnt_mode = 0;
    base_addr = 10'h040; m_base = 'h040;
    clear_idle();
    send_word($urandom, 0, lat);
    send_word($urandom, 0, lat);
    gnt_mode = 2; stall_len = 3;
    send_word($urandom, 1, lat);
    gnt_mode = 0;
    send_word($urandom, 0, lat);
    send_word($urandom, 2, lat);
    send_word($urandom, 0, lat);

    // enable dropped mid-WRITE with start_sram still high
    gnt_mode = 2; stall_len = 4;
    expq.push_back(model_issue(32'hA5A5_0001));
    data_in = 32'hA5A5_0001;
    start_sram = 1'b1;
    tick();
    enable = 1'b0;
    wait_done("en_drop");
    reqs = 0;
    repeat (12) begin
      @(negedge wb_clk);
      if (sram_req) reqs++;
    end
    check("no_req_while_disabled", reqs, 0);
    start_sram = 1'b0;
    enable = 1'b1;
    tick();

    // reset during WRITE: word lost, offset cleared
    gnt_mode = 2; stall_len = 20;
    lat = int'(model_issue(32'hDEAD_BEEF).off);
    data_in = 32'hDEAD_BEEF;
    start_sram = 1'b1;
    tick();
    tick();
    check("req_before_rst", sram_req, 1'b1);
    wb_rst = 1'b1;
    start_sram = 1'b0;
    tick();
    check("rst_mid_req", sram_req, 1'b0);
    check("rst_mid_offset", wr_offset, '0);
    check("rst_mid_done", data_done, 1'b0);
`ifdef DAQ_SRAM_WRITER_STATS_EN
    check("rst_mid_words", words_written, '0);
`endif
    wb_rst = 1'b0;
    m_off = 0;
    repeat (4) tick();

    // buffer_words = 0: full 1024-word ring
    gnt_mode = 0;
    base_addr = 10'h005; m_base = 5;
    buffer_words = '0; m_len = 0;
    burst(RING + 1);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      if (i % 12 == 0) begin
        m_base = $urandom_range(0, RING - 1);
        m_len  = $urandom_range(1, 8);
        base_addr    = AW'(m_base);
        buffer_words = AW'(m_len);
        clear_idle();
      end
      if ($urandom_range(0, 3) == 0) begin
        gnt_mode = 2;
        stall_len = $urandom_range(0, 4);
      end else begin
        gnt_mode = 1;
      end
      send_word($urandom, ($urandom_range(0, 5) < 2) ? int'($urandom_range(1, 2)) : 0, lat);
    end

    repeat (5) tick();
    check("queue_drained", expq.size(), 0);
`ifdef DAQ_SRAM_WRITER_STATS_EN
    check("words_written", words_written, done_since_rst);
`else
    check("words_written_tied", words_written, '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
